// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on the free-running reference clock.
// Define PLL_LOCK_LOSS_COUNT_EN to keep a saturating count of lock losses seen in RUN.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMER_W        = 17,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count
);

    typedef enum logic [1:0] {
        S_PLL_RESET = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               locked_p0;
    logic               locked_p1;
    logic               lk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // locked is asynchronous to refclk: two-flop synchronizer
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_p0 <= 1'b0;
            locked_p1 <= 1'b0;
        end else begin
            locked_p0 <= locked;
            locked_p1 <= locked_p0;
        end
    end

    assign lk = locked_p1;

    // Outputs are written together with the state they belong to, so they
    // change on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_PLL_RESET;
            timer       <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            retry_count <= '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
            loss_count  <= '0;
`endif
        end else begin
            case (state)
                S_PLL_RESET: begin
                    if (timer == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock on the timeout cycle wins over a retry
                    if (lk) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state       <= S_PLL_RESET;
                        timer       <= '0;
                        pll_rst     <= 1'b1;
                        retry_count <= sat_inc(retry_count);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state   <= S_RUN;
                        timer   <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state      <= S_PLL_RESET;
                        timer      <= '0;
                        pll_rst    <= 1'b1;
                        sys_rst    <= 1'b1;
                        ready      <= 1'b0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
                        loss_count <= sat_inc(loss_count);
`endif
                    end
                end
                default: begin
                    state   <= S_PLL_RESET;
                    timer   <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

`ifndef PLL_LOCK_LOSS_COUNT_EN
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock waveforms,
// every cycle compared against a timestamp-based behavioural model.
module tb_pll_lock_supervisor;

    localparam int PRC = 4;
    localparam int LT  = 20;
    localparam int SC  = 8;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic          locked = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] retry_count;
    logic [CW-1:0] loss_count;

    int checks = 0;
    int passed = 0;

    // reference model: phase plus the cycle on which it was entered
    int   cyc = 0;
    int   phase = PH_RESET;
    int   entered = 0;
    int   retries = 0;
    int   losses = 0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .TIMER_W       (5),
        .CNT_W         (CW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int exp_loss(input int v);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic enter(input int ph);
        phase   = ph;
        entered = cyc;
    endtask

    task automatic model_edge();
        logic lk_now;
        int   t;
        lk_now = s2;
        if (rst) begin
            enter(PH_RESET);
            retries = 0;
            losses  = 0;
            s1 = 1'b0;
            s2 = 1'b0;
        end else begin
            t = cyc - entered - 1;
            if (phase == PH_RESET && t == PRC - 1) enter(PH_WAIT);
            else if (phase == PH_WAIT && lk_now) enter(PH_STABLE);
            else if (phase == PH_WAIT && t == LT - 1) begin
                enter(PH_RESET);
                retries = sat(retries);
            end
            else if (phase == PH_STABLE && !lk_now) enter(PH_WAIT);
            else if (phase == PH_STABLE && t == SC - 1) enter(PH_RUN);
            else if (phase == PH_RUN && !lk_now) begin
                enter(PH_RESET);
                losses = sat(losses);
            end
            s2 = s1;
            s1 = locked;
        end
        cyc++;
    endtask

    task automatic step(input logic l, input logic r);
        @(negedge refclk);
        locked = l;
        rst    = r;
        @(posedge refclk);
        model_edge();
        #1;
        check("pll_rst", 32'(pll_rst), 32'(phase == PH_RESET));
        check("sys_rst", 32'(sys_rst), 32'(phase != PH_RUN));
        check("ready", 32'(ready), 32'(phase == PH_RUN));
        check("retry_count", 32'(retry_count), 32'(retries));
        check("loss_count", 32'(loss_count), 32'(exp_loss(losses)));
    endtask

    task automatic hold_until_ready(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0);
            n++;
            if (ready) break;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    task automatic count_pll_high(output int n);
        n = pll_rst ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            step(locked, 1'b0);
            if (pll_rst) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        int seen;

        // Test 1: power-up sequence
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_sys_rst", 32'(sys_rst), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_loss", 32'(loss_count), 32'd0);
        count_pll_high(n);
        check("t1_pll_rst_len", 32'(n), 32'(PRC));
        repeat (4) step(1'b0, 1'b0);
        // 2 sync cycles, 1 detect cycle in WAIT_LOCK, then SC stable cycles
        hold_until_ready("t1_ready_reached", n);
        check("t1_ready_latency", 32'(n), 32'(2 + 1 + SC));
        check("t1_retry", 32'(retry_count), 32'd0);

        // Test 2: no lock, periodic retries
        step(1'b0, 1'b1);
        for (int i = 0; i < 3 * (PRC + LT); i++) step(1'b0, 1'b0);
        check("t2_retry3", 32'(retry_count), 32'd3);
        check("t2_sys_rst", 32'(sys_rst), 32'd1);
        count_pll_high(n);
        check("t2_pll_rst_len", 32'(n), 32'(PRC));

        // Test 3: one-cycle lock loss in RUN
        step(1'b1, 1'b1);
        hold_until_ready("t3_ready_a", n);
        step(1'b0, 1'b0);
        n = 1;
        for (int i = 0; i < 10 && !sys_rst; i++) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("t3_sys_rst_latency", 32'(n), 32'd3);
        check("t3_ready_low", 32'(ready), 32'd0);
        count_pll_high(n);
        check("t3_pll_rst_len", 32'(n), 32'(PRC));
        check("t3_loss", 32'(loss_count), 32'(exp_loss(1)));
        hold_until_ready("t3_relock", n);

        // Test 4: glitch during STABLE restarts the debounce
        step(1'b1, 1'b1);
        for (int i = 0; i < 50 && phase != PH_STABLE; i++) step(1'b1, 1'b0);
        check("t4_in_stable", 32'(phase), 32'(PH_STABLE));
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n = 1;
        seen = 0;
        for (int i = 0; i < 100 && !ready; i++) begin
            step(1'b1, 1'b0);
            n++;
            if (pll_rst) seen++;
        end
        check("t4_ready_latency", 32'(n), 32'(2 + 2 + SC));
        check("t4_pll_rst_quiet", 32'(seen), 32'd0);
        check("t4_retry", 32'(retry_count), 32'd0);
        check("t4_loss", 32'(loss_count), 32'd0);

        // Test 5: rst during RUN clears counters
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            hold_until_ready("t5_relock", n);
        end
        check("t5_loss3", 32'(loss_count), 32'(exp_loss(3)));
        step(1'b1, 1'b1);
        check("t5_pll_rst", 32'(pll_rst), 32'd1);
        check("t5_sys_rst", 32'(sys_rst), 32'd1);
        check("t5_ready", 32'(ready), 32'd0);
        check("t5_retry", 32'(retry_count), 32'd0);
        check("t5_loss", 32'(loss_count), 32'd0);

        // Test 6: loss counter saturation
        hold_until_ready("t6_first_run", n);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0);
            hold_until_ready("t6_relock", n);
        end
        check("t6_loss_sat", 32'(loss_count), 32'(exp_loss(CMAX)));

        // Random lock waveforms with occasional rst
        step(1'b0, 1'b1);
        for (int seg = 0; seg < 150; seg++) begin
            logic lv;
            int   len;
            lv  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) step(lv, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
